// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_pkg
// Shared pipeline widths, NOP encoding and the fetch queue entry type.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;
    localparam int PC_W  = 32;
    localparam int INS_W = 32;

    // sll $0,$0,0
    localparam logic [INS_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]  pc4;
        logic [INS_W-1:0] ins;
    } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/fq_storage.sv
//------------------------------------------------------------------------------
// Module : fq_storage
// DEPTH x 64-bit entry array: one synchronous write port, one async read port.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fq_storage
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    // Contents are intentionally not reset; readers gate on occupancy.
    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pipe_fetch_queue.sv
//------------------------------------------------------------------------------
// Module : pipe_fetch_queue
// Instruction prefetch queue between IF and the IF/ID register; head is a NOP
// bubble when empty. Optional zero-latency path: FETCH_QUEUE_BYPASS_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     f_valid,
    input  logic [31:0]              f_ins,
    input  logic [31:0]              f_pc4,
    output logic                     f_ready,
    input  logic                     flush,
    input  logic                     wpcir,
    output logic                     q_valid,
    output logic [31:0]              q_ins,
    output logic [31:0]              q_pc4,
    output logic [$clog2(DEPTH):0]   q_count
);
    import pipe_pkg::fetch_entry_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    fetch_entry_t head;
    fetch_entry_t wentry;
    logic         empty;
    logic         push;
    logic         store;
    logic         pop;
    logic         bypass;

    assign empty   = (count == '0);
    assign f_ready = (count != CW'(DEPTH));
    assign q_count = count;
    assign push    = f_valid & f_ready;
    assign pop     = wpcir & ~empty;
    assign wentry  = '{pc4: f_pc4, ins: f_ins};

`ifdef FETCH_QUEUE_BYPASS_EN
    // An entry consumed straight from IF in the same cycle is never written.
    assign bypass  = empty & f_valid & ~flush;
    assign store   = push & ~(bypass & wpcir);
    assign q_valid = ~empty | bypass;

    always_comb begin
        q_ins = NOP_INST;
        q_pc4 = 32'h0;
        if (bypass) begin
            q_ins = f_ins;
            q_pc4 = f_pc4;
        end else if (!empty) begin
            q_ins = head.ins;
            q_pc4 = head.pc4;
        end
    end
`else
    assign bypass  = 1'b0;
    assign store   = push;
    assign q_valid = ~empty;

    always_comb begin
        q_ins = NOP_INST;
        q_pc4 = 32'h0;
        if (!empty) begin
            q_ins = head.ins;
            q_pc4 = head.pc4;
        end
    end
`endif

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clock (clock),
        .we    (store & ~flush),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Flush wins over any concurrent push or pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch_queue.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_fetch_queue
// Scoreboard bench for pipe_fetch_queue (DEPTH=4), default and bypass builds.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_ins = '0;
    logic [31:0] f_pc4 = '0;
    logic        f_ready;
    logic        flush = 1'b0;
    logic        wpcir = 1'b0;
    logic        q_valid;
    logic [31:0] q_ins;
    logic [31:0] q_pc4;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    pipe_fetch_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .f_valid (f_valid),
        .f_ins   (f_ins),
        .f_pc4   (f_pc4),
        .f_ready (f_ready),
        .flush   (flush),
        .wpcir   (wpcir),
        .q_valid (q_valid),
        .q_ins   (q_ins),
        .q_pc4   (q_pc4),
        .q_count (q_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed head must match the oldest expected entry.
    always @(negedge clock) begin
        if (resetn && !flush) begin
            if (q_valid && wpcir) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_head: got %h with empty scoreboard", q_ins);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk("head_ins", q_ins, e[31:0]);
                    chk("head_pc4", q_pc4, e[63:32]);
                end
            end else if (!q_valid) begin
                chk("bubble_ins", q_ins, NOP);
                chk("bubble_pc4", q_pc4, 32'h0);
            end
        end
    end

    // One cycle of stimulus; exp_push records the entry the queue should keep.
    task automatic drive(input logic fv, input logic [31:0] ins, input logic wp,
                         input logic fl, input logic exp_push);
        @(posedge clock);
        #1;
        f_valid = fv;
        f_ins   = ins;
        f_pc4   = ins + 32'h1000;
        wpcir   = wp;
        flush   = fl;
        if (fl) sb.delete();
        if (exp_push) sb.push_back({ins + 32'h1000, ins});
    endtask

    task automatic state(input string name, input int cnt, input logic rdy);
        #2;
        chk({name, "_count"}, 32'(q_count), cnt);
        chk({name, "_ready"}, 32'(f_ready), 32'(rdy));
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(q_valid), 0);
        chk("rst_ins", q_ins, NOP);
        chk("rst_pc4", q_pc4, 32'h0);
        chk("rst_count", 32'(q_count), 0);
        chk("rst_ready", 32'(f_ready), 1);
        @(posedge clock); #1 resetn = 1'b1;

        // Fill to DEPTH with the ID stage stalled; the fifth word is refused.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2001_0001 + i, 1'b0, 1'b0, 1'b1);
            state("fill", i, 1'b1);
        end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        state("full", 4, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        state("full_hold", 4, 1'b0);

        // Drain in order, then one pop against an empty queue.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            state("drain", 4 - i, i == 0 ? 1'b0 : 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("drain_empty", 0, 1'b1);
        chk("drain_empty_valid", 32'(q_valid), 0);

        // Steady push+pop at occupancy 2; pointers wrap several times.
        drive(1'b1, 32'h3000_0000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h3000_0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h3000_0002 + i, 1'b1, 1'b0, 1'b1);
            state("pushpop", 2, 1'b1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("pp_drain", 2, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("pp_drain", 1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        state("pp_done", 0, 1'b1);

        // Flush at count 3 with a concurrent push that must be dropped.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000_0000 + i, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b0);
        state("flush_cycle", 3, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("post_flush", 0, 1'b1);
        chk("post_flush_valid", 32'(q_valid), 0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("post_flush2", 0, 1'b1);

        // Empty queue, fetch arrives while ID advances.
        drive(1'b1, 32'h8C22_0004, 1'b1, 1'b0, 1'b1);
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bypass_valid", 32'(q_valid), 1);
        chk("bypass_ins", q_ins, 32'h8C22_0004);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("bypass_next", 0, 1'b1);
`else
        chk("nobypass_valid", 32'(q_valid), 0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("nobypass_next", 1, 1'b1);
        chk("nobypass_ins", q_ins, 32'h8C22_0004);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        state("nobypass_done", 0, 1'b1);
`endif

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        state("pre_reset", 3, 1'b1);
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 32'(q_valid), 0);
        chk("mid_rst_ins", q_ins, NOP);
        chk("mid_rst_count", 32'(q_count), 0);
        chk("mid_rst_ready", 32'(f_ready), 1);
        @(posedge clock); #1 resetn = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        state("after_reset", 0, 1'b1);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("scoreboard_left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
